pipe_reg_elastic: RTL and testbench

//  Parametrised elastic pipeline register; successor to the fixed per-stage registers (IF/ID .. MEM/WB).

---
 rtl/pipe_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/pipe_reg_elastic.sv | 166 ++++++++++++++++
 tb/tb_pipe_reg_elastic.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline register and its stage wrappers.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_BUSY,
        ST_FULL
    } pipe_state_t;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones, cleared only by rst.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic valid/ready pipeline register with flush-to-bubble, optional 2-entry skid and stall counter.
// Control bits never leave the block while out_valid=0, so bubbles cannot write state downstream.
//
// state    | meaning
// ST_EMPTY | no word held, in_ready=1
// ST_BUSY  | output register holds a word, skid empty, in_ready=1
// ST_FULL  | output and skid registers both hold words, in_ready=0
module pipe_reg_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;
    logic              load_in;
    logic              load_skid;
    logic              drain;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;

    generate
        if (SKID) begin : g_skid
            pipe_state_t state_q;
            pipe_state_t state_d;
            logic        ready_q;
            logic        ready_d;
            logic        skid_load;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state_q <= state_d;
                    ready_q <= ready_d;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    skid_ctrl <= '0;
                    skid_data <= '0;
                end else if (skid_load) begin
                    skid_ctrl <= in_ctrl;
                    skid_data <= in_data;
                end
            end

            always_comb begin
                state_d   = state_q;
                ready_d   = ready_q;
                load_in   = 1'b0;
                load_skid = 1'b0;
                drain     = 1'b0;
                skid_load = 1'b0;
                if (flush) begin
                    state_d = ST_EMPTY;
                    ready_d = 1'b1;
                end else begin
                    unique case (state_q)
                        ST_EMPTY: begin
                            ready_d = 1'b1;
                            if (in_fire) begin
                                load_in = 1'b1;
                                state_d = ST_BUSY;
                            end
                        end
                        ST_BUSY: begin
                            if (in_fire && out_fire) begin
                                load_in = 1'b1;
                            end else if (in_fire) begin
                                // Downstream stalled: park the new word and close the input.
                                skid_load = 1'b1;
                                ready_d   = 1'b0;
                                state_d   = ST_FULL;
                            end else if (out_fire) begin
                                drain   = 1'b1;
                                state_d = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (out_fire) begin
                                load_skid = 1'b1;
                                ready_d   = 1'b1;
                                state_d   = ST_BUSY;
                            end
                        end
                        default: begin
                            drain   = 1'b1;
                            ready_d = 1'b1;
                            state_d = ST_EMPTY;
                        end
                    endcase
                end
            end

            assign in_ready = ready_q;
        end else begin : g_flow
            assign in_ready  = out_ready | ~main_valid;
            assign load_in   = in_fire;
            assign load_skid = 1'b0;
            assign drain     = out_fire & ~in_fire;
            assign skid_ctrl = '0;
            assign skid_data = '0;
        end
    endgenerate

    // Flush keeps out_data so a debugger still sees the last killed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
        end else if (load_in) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
        end else if (load_skid) begin
            main_valid <= 1'b1;
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
        end else if (drain) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (main_valid & ~out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed and scoreboarded random checks of pipe_reg_elastic; index 0 is SKID=0, index 1 is SKID=1.
module tb_pipe_reg_elastic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       flush;
    logic [1:0]       in_valid;
    logic [1:0]       out_ready;
    logic [1:0][3:0]  in_ctrl;
    logic [1:0][31:0] in_data;
    wire  [1:0]       in_ready;
    wire  [1:0]       out_valid;
    wire  [1:0][3:0]  out_ctrl;
    wire  [1:0][31:0] out_data;
    wire  [1:0][3:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

    pipe_reg_elastic #(.DATA_W(32), .CTRL_W(4), .SKID(1'b0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst[0]), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]), .out_data(out_data[0]),
        .stall_cnt(stall_cnt[0])
    );

    pipe_reg_elastic #(.DATA_W(32), .CTRL_W(4), .SKID(1'b1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst[1]), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]), .out_data(out_data[1]),
        .stall_cnt(stall_cnt[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL skid%0d %s: observed=%0h expected=%0h", k, tag, obs, exp);
        end
    endtask

    task automatic run_directed(input int k);
        int st;
        // reset with garbage on the inputs
        rst[k] = 1'b1; flush[k] = 1'b0; out_ready[k] = 1'b1;
        in_valid[k] = 1'b1; in_ctrl[k] = 4'hF; in_data[k] = 32'h55;
        tick(); tick();
        chk(k, "rst_out_valid", out_valid[k], 0);
        chk(k, "rst_out_ctrl", out_ctrl[k], 0);
        chk(k, "rst_out_data", out_data[k], 0);
        chk(k, "rst_stall_cnt", stall_cnt[k], 0);
        rst[k] = 1'b0; in_valid[k] = 1'b0;
        tick();
        chk(k, "rel_in_ready", in_ready[k], 1);
        chk(k, "rel_out_valid", out_valid[k], 0);

        // streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            in_valid[k] = 1'b1; in_data[k] = 32'(i); in_ctrl[k] = 4'(i);
            tick();
            chk(k, "stream_valid", out_valid[k], 1);
            chk(k, "stream_data", out_data[k], 32'(i));
            chk(k, "stream_ctrl", out_ctrl[k], 32'(i & 15));
            chk(k, "stream_in_ready", in_ready[k], 1);
        end
        in_valid[k] = 1'b0;
        tick();
        chk(k, "stream_end_valid", out_valid[k], 0);
        chk(k, "stream_end_ctrl", out_ctrl[k], 0);
        chk(k, "stream_end_data_hold", out_data[k], 8);
        chk(k, "stream_stall_cnt", stall_cnt[k], 0);

        // back-pressure: A accepted, then output stalls
        out_ready[k] = 1'b0;
        in_valid[k] = 1'b1; in_data[k] = 32'hA0; in_ctrl[k] = 4'h1;
        tick();
        chk(k, "bp_a_valid", out_valid[k], 1);
        chk(k, "bp_a_data", out_data[k], 32'hA0);
        in_data[k] = 32'hB0; in_ctrl[k] = 4'h2;
        if (k == 1) begin
            tick();
            chk(k, "bp_full_in_ready", in_ready[k], 0);
            chk(k, "bp_full_data", out_data[k], 32'hA0);
            chk(k, "bp_full_stall", stall_cnt[k], 1);
            in_data[k] = 32'hC0; in_ctrl[k] = 4'h3;
            tick(); tick();
            chk(k, "bp_c_blocked", in_ready[k], 0);
            chk(k, "bp_hold_a", out_data[k], 32'hA0);
            chk(k, "bp_stall3", stall_cnt[k], 3);
            out_ready[k] = 1'b1;
            tick();
            chk(k, "bp_out_b", out_data[k], 32'hB0);
            chk(k, "bp_out_b_ctrl", out_ctrl[k], 2);
            chk(k, "bp_reopen", in_ready[k], 1);
            tick();
            chk(k, "bp_out_c", out_data[k], 32'hC0);
            chk(k, "bp_out_c_ctrl", out_ctrl[k], 3);
            in_valid[k] = 1'b0;
            tick();
            chk(k, "bp_drained", out_valid[k], 0);
            chk(k, "bp_stall_final", stall_cnt[k], 3);
            st = 3;
        end else begin
            chk(k, "bp_in_ready_low", in_ready[k], 0);
            tick(); tick();
            chk(k, "bp_hold_a", out_data[k], 32'hA0);
            chk(k, "bp_stall2", stall_cnt[k], 2);
            out_ready[k] = 1'b1;
            #1;
            chk(k, "bp_in_ready_comb", in_ready[k], 1);
            tick();
            chk(k, "bp_out_b", out_data[k], 32'hB0);
            chk(k, "bp_out_b_ctrl", out_ctrl[k], 2);
            in_valid[k] = 1'b0;
            tick();
            chk(k, "bp_drained", out_valid[k], 0);
            chk(k, "bp_stall_final", stall_cnt[k], 2);
            st = 2;
        end

        // flush with a word D offered in the same cycle
        out_ready[k] = 1'b0;
        in_valid[k] = 1'b1; in_data[k] = 32'hE0; in_ctrl[k] = 4'h5;
        tick();
        if (k == 1) begin
            in_data[k] = 32'hF0; in_ctrl[k] = 4'h6;
            tick();
            st++;
            chk(k, "fl_full", in_ready[k], 0);
            chk(k, "fl_full_stall", stall_cnt[k], 32'(st));
        end
        flush[k] = 1'b1; in_data[k] = 32'hD0; in_ctrl[k] = 4'h7;
        tick();
        st++;
        chk(k, "fl_out_valid", out_valid[k], 0);
        chk(k, "fl_out_ctrl", out_ctrl[k], 0);
        chk(k, "fl_in_ready", in_ready[k], 1);
        chk(k, "fl_data_kept", out_data[k], 32'hE0);
        chk(k, "fl_stall", stall_cnt[k], 32'(st));
        flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
        tick();
        chk(k, "fl_no_d", out_valid[k], 0);
        tick();
        chk(k, "fl_no_d2", out_valid[k], 0);

        // stall counter saturation
        out_ready[k] = 1'b0;
        in_valid[k] = 1'b1; in_data[k] = 32'h60; in_ctrl[k] = 4'h8;
        tick();
        in_valid[k] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            chk(k, "sat_step", stall_cnt[k], (st + n > 15) ? 32'd15 : 32'(st + n));
        end
        chk(k, "sat_valid_held", out_valid[k], 1);
        flush[k] = 1'b1;
        tick();
        flush[k] = 1'b0;
        chk(k, "sat_flush_keeps", stall_cnt[k], 15);
        rst[k] = 1'b1;
        tick();
        rst[k] = 1'b0;
        chk(k, "sat_rst_clears", stall_cnt[k], 0);
    endtask

    task automatic run_random(input int k, input int ncyc);
        logic [35:0] q[$];
        logic [31:0] seq;
        logic        fi;
        logic        fo;
        rst[k] = 1'b1; flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
        tick();
        rst[k] = 1'b0;
        seq = 32'h1000;
        for (int c = 0; c < ncyc; c++) begin
            in_valid[k]  = ($urandom_range(0, 99) < 60);
            out_ready[k] = ($urandom_range(0, 99) < 50);
            flush[k]     = ($urandom_range(0, 63) == 0);
            in_data[k]   = seq;
            in_ctrl[k]   = 4'(seq % 15) + 4'd1;
            #1;
            fi = in_valid[k] & in_ready[k];
            fo = out_valid[k] & out_ready[k];
            tick();
            if (flush[k]) begin
                q.delete();
            end else begin
                if (fo && q.size() > 0) void'(q.pop_front());
                if (fi) begin
                    q.push_back({4'(seq % 15) + 4'd1, seq});
                    seq++;
                end
            end
            chk(k, "rnd_valid", out_valid[k], 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk(k, "rnd_data", out_data[k], q[0][31:0]);
                chk(k, "rnd_ctrl", out_ctrl[k], 32'(q[0][35:32]));
            end else begin
                chk(k, "rnd_bubble_ctrl", out_ctrl[k], 0);
            end
            if (k == 1) chk(k, "rnd_in_ready", in_ready[k], 32'(q.size() < 2));
            else        chk(k, "rnd_depth", 32'(q.size() <= 1), 1);
        end
        flush[k] = 1'b0; in_valid[k] = 1'b0;
    endtask

    initial begin
        rst = 2'b11; flush = 2'b00; in_valid = 2'b00; out_ready = 2'b00;
        in_ctrl = '0; in_data = '0;
        run_directed(1);
        run_directed(0);
        run_random(1, 5000);
        run_random(0, 5000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
